// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: load/store funct3 codes, FSM encodings, byte-enable masks.
package mem_stage_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_BUS  = 1'b1;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus req/ack interface between the memory stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            be;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store enables/replication, load select/extend, access error.
// Zero latency; no flow control of its own.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  is_load,
  input  logic                  is_store,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misaligned;
  logic        illegal;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Store codes share encodings with LB/LH/LW; LBU/LHU have no store counterpart.
  always_comb begin
    be         = BE_NONE;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      LB: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
      end
      LH: begin
        load_data  = {{16{half_sel[15]}}, half_sel};
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      LW: begin
        be         = BE_ALL;
        misaligned = |addr_lo;
      end
      LBU: begin
        load_data = {24'd0, byte_sel};
        illegal   = is_store;
      end
      LHU: begin
        load_data  = {16'd0, half_sel};
        misaligned = addr_lo[0];
        illegal    = is_store;
      end
      default: illegal = 1'b1;
    endcase
    if (is_load && is_store) illegal = 1'b1;
    err = (is_load | is_store) & (misaligned | illegal);
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU results pass in 1 cycle; loads/stores run a req/ack bus access (2 cycles + waits).
// Holds upstream via stall_o while an access is being issued or awaits ack.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   mem_re_i,
  input  logic                   mem_we_i,
  input  logic [2:0]             mem_funct3_i,
  input  logic [DATA_WIDTH-1:0]  mem_wdata_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   valid_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   err_o,
  mem_stage_if.master            dbus
);

  logic [0:0] state;
  logic [2:0] q_funct3;
  logic [1:0] q_addr_lo;
  logic       q_re;
  logic       q_rwe;
  logic       flush_pend;

  logic                  in_bus;
  logic                  mem_op;
  logic                  aligned_op;
  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_load_data;
  logic                  al_err;

  assign in_bus     = (state == MEM_BUS);
  assign mem_op     = valid_i & (mem_re_i | mem_we_i);
  assign aligned_op = mem_op & ~al_err;
  assign stall_o    = (~in_bus & aligned_op & ~flush_i) | (in_bus & ~dbus.ack);

  // While a transaction is open the aligner formats the latched request, not the held inputs.
  mem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (in_bus ? q_funct3  : mem_funct3_i),
    .addr_lo    (in_bus ? q_addr_lo : reg_wdata_i[1:0]),
    .store_data (mem_wdata_i),
    .rdata      (dbus.rdata),
    .is_load    (in_bus ? q_re      : mem_re_i),
    .is_store   (in_bus ? dbus.we   : mem_we_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .err        (al_err)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= MEM_IDLE;
      q_funct3    <= 3'd0;
      q_addr_lo   <= 2'd0;
      q_re        <= 1'b0;
      q_rwe       <= 1'b0;
      flush_pend  <= 1'b0;
      valid_o     <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      err_o       <= 1'b0;
      dbus.req    <= 1'b0;
      dbus.we     <= 1'b0;
      dbus.addr   <= '0;
      dbus.wdata  <= '0;
      dbus.be     <= BE_NONE;
    end else begin
      case (state)
        MEM_IDLE: begin
          valid_o     <= 1'b0;
          err_o       <= 1'b0;
          reg_we_o    <= 1'b0;
          reg_waddr_o <= reg_waddr_i;
          reg_wdata_o <= reg_wdata_i;
          if (valid_i && !flush_i) begin
            if (!mem_op) begin
              valid_o  <= 1'b1;
              reg_we_o <= reg_we_i;
            end else if (al_err) begin
              valid_o <= 1'b1;
              err_o   <= 1'b1;
            end else begin
              dbus.req   <= 1'b1;
              dbus.we    <= mem_we_i;
              dbus.addr  <= {reg_wdata_i[DATA_WIDTH-1:2], 2'b00};
              dbus.wdata <= al_wdata;
              dbus.be    <= al_be;
              q_funct3   <= mem_funct3_i;
              q_addr_lo  <= reg_wdata_i[1:0];
              q_re       <= mem_re_i;
              q_rwe      <= reg_we_i;
              flush_pend <= 1'b0;
              state      <= MEM_BUS;
            end
          end
        end
        MEM_BUS: begin
          if (flush_i) flush_pend <= 1'b1;
          // A flushed access still completes on the bus; only its writeback is suppressed.
          if (dbus.ack) begin
            dbus.req    <= 1'b0;
            state       <= MEM_IDLE;
            valid_o     <= ~(flush_pend | flush_i);
            reg_we_o    <= q_re & q_rwe & ~(flush_pend | flush_i);
            reg_wdata_o <= al_load_data;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule
